// File: rtl/wb_pipe_master.sv
// Wishbone B.4 pipelined bus master: turns a valid/ready command stream into
// back-to-back strobes within one bus cycle and returns in-order responses.
module wb_pipe_master #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  // command port
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  input  logic                    cmd_last_i,
  // response port
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic                    rsp_err_o,
  // Wishbone master side
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic                    we_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    stall_i
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   MAX_INFLIGHT = (CNT_WIDTH + 1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       out_cnt_q, out_cnt_d;
  logic [CNT_WIDTH-1:0]       push_idx;
  logic [CNT_WIDTH:0]         inflight;
  // One bit per outstanding transfer, oldest at index 0: 1 = write.
  logic [MAX_OUTSTANDING-1:0] we_q, we_d;

  logic bus_take;
  logic term;
  logic cmd_fire;

  assign bus_take = stb_o & ~stall_i;
  assign term     = (ack_i | err_i) & (out_cnt_q != '0);
  assign cmd_fire = cmd_valid_i & cmd_ready_o;

  // Strobe currently on the bus counts as in flight, so a new command can
  // never push the outstanding count past MAX_OUTSTANDING.
  assign inflight = {1'b0, out_cnt_q} + {{CNT_WIDTH{1'b0}}, stb_o};

  // NOTE: reset_ni gates ready combinationally so no command is taken while
  // the block is held in reset, even though the registers already read idle.
  assign cmd_ready_o = reset_ni
                     & (state_q != S_DRAIN)
                     & (~stb_o | ~stall_i)
                     & (inflight < MAX_INFLIGHT);

  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (bus_take && !term) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!bus_take && term) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end
  end

  // Pop the terminated transfer first, then append the newly taken strobe.
  always_comb begin
    we_d     = term ? (we_q >> 1) : we_q;
    push_idx = term ? (out_cnt_q - CNT_ONE) : out_cnt_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (bus_take && (push_idx == CNT_WIDTH'(i))) begin
        we_d[i] = we_o;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = cmd_last_i ? S_DRAIN : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cmd_fire && cmd_last_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!stb_o && (out_cnt_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      out_cnt_q <= '0;
      cyc_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      cyc_o     <= (state_d != S_IDLE);
    end
  end

  // NOTE: the direction shadow is only MAX_OUTSTANDING flops, so it is reset
  // along with the counter rather than left as an unreset storage array.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      we_q <= '0;
    end else begin
      we_q <= we_d;
    end
  end

  // Bus command registers: load on accept, hold while stalled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      we_o  <= 1'b0;
      stb_o <= 1'b0;
    end else if (cmd_fire) begin
      adr_o <= cmd_adr_i;
      dat_o <= cmd_dat_i;
      sel_o <= cmd_sel_i;
      we_o  <= cmd_we_i;
      stb_o <= 1'b1;
    end else if (bus_take) begin
      stb_o <= 1'b0;
    end
  end

  // Terminations with nothing outstanding never reach the response port.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      rsp_valid_o <= term;
      rsp_err_o   <= term & err_i;
      if (term && !we_q[0]) begin
        rsp_dat_o <= dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_master.sv
// Directed bench for wb_pipe_master: scripted slave, queue-based reference
// model compared every cycle, plus literal expectations per scenario.
module tb_wb_pipe_master;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;

  logic          clk_i       = 1'b0;
  logic          reset_ni    = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i    = 1'b0;
  logic [AW-1:0] cmd_adr_i   = '0;
  logic [DW-1:0] cmd_dat_i   = '0;
  logic [SW-1:0] cmd_sel_i   = '0;
  logic          cmd_last_i  = 1'b0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic          we_o;
  logic          cyc_o;
  logic          stb_o;
  logic [DW-1:0] dat_i   = '0;
  logic          ack_i   = 1'b0;
  logic          err_i   = 1'b0;
  logic          stall_i = 1'b0;

  wb_pipe_master #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .cmd_last_i  (cmd_last_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .sel_o       (sel_o),
    .we_o        (we_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .dat_i       (dat_i),
    .ack_i       (ack_i),
    .err_i       (err_i),
    .stall_i     (stall_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic          m_cyc, m_stb, m_we, m_drain;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic          m_rsp_valid, m_rsp_err;
  logic [DW-1:0] m_rsp_dat;
  bit            m_q[$];           // directions of accepted, unterminated strobes
  logic          m_fire, m_old_stb, m_old_drain;

  function automatic logic m_ready();
    return reset_ni && !m_drain && (!m_stb || !stall_i) && ((m_q.size() + int'(m_stb)) < MAXO);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_stb = 0; m_we = 0; m_drain = 0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_rsp_valid = 0; m_rsp_err = 0; m_rsp_dat = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    m_fire      = cmd_valid_i && m_ready();
    m_old_stb   = m_stb;
    m_old_drain = m_drain;
    m_rsp_valid = 0;
    m_rsp_err   = 0;
    if ((ack_i || err_i) && m_q.size() > 0) begin
      if (!m_q.pop_front()) m_rsp_dat = dat_i;
      m_rsp_valid = 1;
      m_rsp_err   = err_i;
    end
    if (m_stb && !stall_i) m_q.push_back(m_we);
    if (m_fire) begin
      m_adr = cmd_adr_i; m_dat = cmd_dat_i; m_sel = cmd_sel_i; m_we = cmd_we_i;
      m_stb = 1; m_cyc = 1;
      if (cmd_last_i) m_drain = 1;
    end else if (m_stb && !stall_i) begin
      m_stb = 0;
    end
    if (m_old_drain && !m_old_stb && m_q.size() == 0) begin
      m_drain = 0;
      m_cyc   = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge reset_ni);
      if (!reset_ni) model_reset();
      else model_step();
    end
  end

  // ---------------- compare + monitor on the falling edge ----------------
  bit            rsp_log_err[$];
  bit            rsp_log_cyc[$];
  logic [DW-1:0] rsp_log_dat[$];
  logic [AW-1:0] acc_adr[$];
  logic [DW-1:0] acc_dat[$];
  int            stb_cycles  = 0;
  int            adr1_cycles = 0;

  initial forever begin
    @(negedge clk_i);
    check("cyc_o", 32'(cyc_o), 32'(m_cyc));
    check("stb_o", 32'(stb_o), 32'(m_stb));
    check("cmd_ready_o", 32'(cmd_ready_o), 32'(m_ready()));
    check("rsp_valid_o", 32'(rsp_valid_o), 32'(m_rsp_valid));
    check("rsp_dat_o", 32'(rsp_dat_o), 32'(m_rsp_dat));
    if (m_rsp_valid) check("rsp_err_o", 32'(rsp_err_o), 32'(m_rsp_err));
    if (m_stb) begin
      check("adr_o", 32'(adr_o), 32'(m_adr));
      check("dat_o", 32'(dat_o), 32'(m_dat));
      check("sel_o", 32'(sel_o), 32'(m_sel));
      check("we_o", 32'(we_o), 32'(m_we));
    end
    if (rsp_valid_o) begin
      rsp_log_err.push_back(rsp_err_o);
      rsp_log_cyc.push_back(cyc_o);
      rsp_log_dat.push_back(rsp_dat_o);
    end
    if (stb_o) stb_cycles++;
    if (stb_o && adr_o == 16'h0001) adr1_cycles++;
    if (stb_o && !stall_i) begin
      acc_adr.push_back(adr_o);
      acc_dat.push_back(dat_o);
    end
  end

  // ---------------- scripted slave ----------------
  int            pend[$];
  int            acc_n      = 0;
  int            slv_idx    = 0;
  bit            hold_ack   = 0;
  int            stall_idx  = -1;
  int            stall_left = 0;
  int            err_idx    = -1;
  logic [DW-1:0] rd_base    = '0;

  initial forever begin
    @(negedge clk_i);
    if (stb_o && !stall_i) begin
      pend.push_back(acc_n);
      acc_n++;
    end
    @(posedge clk_i);
    #1;
    ack_i   = 0;
    err_i   = 0;
    stall_i = 0;
    if (!hold_ack && pend.size() > 0) begin
      slv_idx = pend.pop_front();
      if (slv_idx == err_idx) err_i = 1;
      else ack_i = 1;
      dat_i = rd_base + DW'(slv_idx);
    end
    if (stb_o && acc_n == stall_idx && stall_left > 0) begin
      stall_i = 1;
      stall_left--;
    end
  end

  // ---------------- stimulus helpers (run at posedge + 2) ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic setup(input logic [DW-1:0] base, input int s_idx, input int s_len,
                       input int e_idx, input bit hold);
    rd_base = base; stall_idx = s_idx; stall_left = s_len; err_idx = e_idx; hold_ack = hold;
    acc_n = 0;
    pend.delete();
    rsp_log_err.delete(); rsp_log_cyc.delete(); rsp_log_dat.delete();
    acc_adr.delete(); acc_dat.delete();
    stb_cycles = 0; adr1_cycles = 0;
  endtask

  task automatic send(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input bit last);
    int n;
    n = 0;
    cmd_valid_i = 1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
    cmd_sel_i = sel; cmd_last_i = last;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk_i);
    #2;
    cmd_valid_i = 0;
    cmd_last_i  = 0;
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k;
    k = 0;
    while (rsp_log_err.size() < n && k < 100) begin
      cycles(1);
      k++;
    end
    check(name, 32'(rsp_log_err.size()), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (cyc_o && k < 100) begin
      cycles(1);
      k++;
    end
    check(name, 32'(cyc_o), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  int n0;

  initial begin
    // 1: reset with a command pending
    cmd_valid_i = 1; cmd_adr_i = 16'h1234; cmd_we_i = 1;
    cycles(3);
    check("t1_cyc", 32'(cyc_o), 32'd0);
    check("t1_stb", 32'(stb_o), 32'd0);
    check("t1_ready", 32'(cmd_ready_o), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("t1_adr", 32'(adr_o), 32'd0);
    check("t1_we", 32'(we_o), 32'd0);
    reset_ni = 1; cmd_valid_i = 0; cmd_we_i = 0;
    #1;
    check("t1_ready_release", 32'(cmd_ready_o), 32'd1);
    cycles(1);

    // 2: single read
    setup(16'hBEEF, -1, 0, -1, 0);
    send(0, 16'h0040, 16'h0000, 2'b10, 1);
    wait_rsp(1, "t2_rsp_count");
    if (rsp_log_dat.size() > 0) check("t2_rsp_dat", 32'(rsp_log_dat[0]), 32'h0000_BEEF);
    wait_idle("t2_cyc_drop");
    check("t2_stb_cycles", 32'(stb_cycles), 32'd1);
    cycles(2);

    // 3: four writes, 2nd strobe stalled for 2 clocks
    setup(16'h0000, 1, 2, -1, 0);
    for (int i = 0; i < 4; i++) send(1, AW'(i), DW'(16'hA0 + i), 2'b11, i == 3);
    wait_rsp(4, "t3_rsp_count");
    wait_idle("t3_cyc_drop");
    check("t3_adr1_held", 32'(adr1_cycles), 32'd3);
    check("t3_bus_count", 32'(acc_adr.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_adr.size(); i++) begin
      check("t3_bus_adr", 32'(acc_adr[i]), 32'(i));
      check("t3_bus_dat", 32'(acc_dat[i]), 32'(16'hA0 + i));
    end
    check("t3_rsp_dat_hold", 32'(rsp_dat_o), 32'h0000_BEEF);
    cycles(2);

    // 4: acks withheld, six reads against MAX_OUTSTANDING = 4
    setup(16'h1000, -1, 0, -1, 1);
    for (int i = 0; i < 4; i++) send(0, AW'(16'h0100 + i), 16'h0000, 2'b11, 0);
    check("t4_ready_low_after_4", 32'(cmd_ready_o), 32'd0);
    cycles(3);
    check("t4_ready_still_low", 32'(cmd_ready_o), 32'd0);
    hold_ack = 0;
    send(0, 16'h0104, 16'h0000, 2'b11, 0);
    send(0, 16'h0105, 16'h0000, 2'b11, 1);
    wait_rsp(6, "t4_rsp_count");
    wait_idle("t4_cyc_drop");
    for (int i = 0; i < 6 && i < rsp_log_dat.size(); i++)
      check("t4_rsp_order", 32'(rsp_log_dat[i]), 32'(16'h1000 + i));
    check("t4_rsp_dat_last", 32'(rsp_dat_o), 32'h0000_1005);
    cycles(2);

    // 5: error on the 2nd of 3 writes
    setup(16'h0000, -1, 0, 1, 0);
    for (int i = 0; i < 3; i++) send(1, AW'(16'h0300 + i), DW'(16'hC0 + i), 2'b01, i == 2);
    wait_rsp(3, "t5_rsp_count");
    wait_idle("t5_cyc_drop");
    if (rsp_log_err.size() == 3) begin
      check("t5_err0", 32'(rsp_log_err[0]), 32'd0);
      check("t5_err1", 32'(rsp_log_err[1]), 32'd1);
      check("t5_err2", 32'(rsp_log_err[2]), 32'd0);
      check("t5_cyc_at_rsp1", 32'(rsp_log_cyc[1]), 32'd1);
      check("t5_cyc_at_rsp3", 32'(rsp_log_cyc[2]), 32'd0);
    end
    cycles(2);

    // 6: reset with two transfers outstanding, late acks afterwards
    setup(16'h2000, -1, 0, -1, 1);
    send(0, 16'h0200, 16'h0000, 2'b11, 0);
    send(0, 16'h0201, 16'h0000, 2'b11, 0);
    cycles(1);
    check("t6_cyc_before", 32'(cyc_o), 32'd1);
    #1;
    reset_ni = 0;
    #1;
    check("t6_cyc_async", 32'(cyc_o), 32'd0);
    check("t6_stb_async", 32'(stb_o), 32'd0);
    cycles(1);
    reset_ni = 1;
    n0 = rsp_log_err.size();
    hold_ack = 0;
    cycles(6);
    check("t6_no_rsp", 32'(rsp_log_err.size()), 32'(n0));
    check("t6_cyc_idle", 32'(cyc_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
